// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the keyboard decoder, the escape decoder, the UART
// transmitter and the transmit arbiter. The master side is the arbiter, which
// owns the transmitter strobe; the slave side is everything around it.
interface uart_tx_arbiter_if;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;
  logic       resp_req;
  logic       resp_ack;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       kbd_overflow;

  modport master (
    input  kbd_data, kbd_valid, resp_req, tx_busy,
    output kbd_ready, resp_ack, tx_data, tx_start, kbd_overflow
  );

  modport slave (
    output kbd_data, kbd_valid, resp_req, tx_busy,
    input  kbd_ready, resp_ack, tx_data, tx_start, kbd_overflow
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the single UART transmitter between buffered keyboard bytes and
// the three-byte VT52 identify answer (ESC / K). The answer has priority and is
// sent atomically; keyboard bytes leave strictly in arrival order.
module uart_tx_arbiter #(
  parameter int FIFO_AW = 3
) (
  input logic               clk50,
  input logic               reset,
  uart_tx_arbiter_if.master bus
);

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               pending;
  logic               rearm;
  logic [1:0]         ans_idx;
  logic [1:0]         wait_cnt;
  logic [7:0]         ans_byte;
  logic               can_send;
  logic               sel_ans;
  logic               sel_kbd;

  assign full          = (count == CNT_MAX);
  assign empty         = (count == '0);
  // The FIFO refuses bytes while reset is held, so nothing sneaks in.
  assign bus.kbd_ready = ~reset & ~full;
  assign push          = bus.kbd_valid & bus.kbd_ready;

  // Pending stays set for the whole answer, so it alone keeps the sequence
  // atomic against a non-empty FIFO.
  assign can_send = (state == IDLE) & ~bus.tx_busy;
  assign sel_ans  = can_send & pending;
  assign sel_kbd  = can_send & ~pending & ~empty;
  assign pop      = sel_kbd;

  // Answer byte selected by the sequence index.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    ans_byte = 8'h4B;
    case (ans_idx)
      2'd0:    ans_byte = 8'h1B;
      2'd1:    ans_byte = 8'h2F;
      default: ans_byte = 8'h4B;
    endcase
  end

  // Keyboard FIFO storage.
  // NOTE: the data array is deliberately not reset; occupancy and pointers
  // decide what is valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr] <= bus.kbd_data;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk50) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bus.kbd_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (bus.kbd_valid && full) bus.kbd_overflow <= 1'b1;
    end
  end

  // Transmit sequencer: request bookkeeping, byte selection and the
  // transmitter handshake, with all outputs registered.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state        <= IDLE;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.resp_ack <= 1'b0;
      pending      <= 1'b0;
      rearm        <= 1'b0;
      ans_idx      <= 2'd0;
      wait_cnt     <= 2'd0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.resp_ack <= 1'b0;

      // Requests before byte 0 merge into pending; requests once the answer
      // is on its way collapse into one re-arm that reloads pending when the
      // last byte is selected.
      if (sel_ans && ans_idx == 2'd2) begin
        pending <= rearm | bus.resp_req;
        rearm   <= 1'b0;
      end else if (bus.resp_req) begin
        if (ans_idx != 2'd0) rearm   <= 1'b1;
        else                 pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sel_ans) begin
            bus.tx_data  <= ans_byte;
            bus.tx_start <= 1'b1;
            state        <= START;
            if (ans_idx == 2'd2) begin
              ans_idx      <= 2'd0;
              bus.resp_ack <= 1'b1;
            end else begin
              ans_idx <= ans_idx + 2'd1;
            end
          end else if (sel_kbd) begin
            bus.tx_data  <= mem[rd_ptr];
            bus.tx_start <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          wait_cnt <= 2'd0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never acknowledges must not stall the path.
          if (bus.tx_busy || wait_cnt == 2'd3) state <= WAIT_DONE;
          else                                  wait_cnt <= wait_cnt + 2'd1;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
